// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter side bundle of the shared UART TX arbiter.
// master = byte producers plus transmitter status, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][7:0] req_byte;
  logic [NUM_REQ-1:0]      grant;
  logic [2:0]              grant_id;
  logic                    busy;
  logic                    timeout;
  logic                    tx_dv;
  logic [7:0]              tx_byte;
  logic                    tx_active;
  logic                    tx_done;

  modport master (
    output req, req_byte, tx_active, tx_done,
    input  grant, grant_id, busy, timeout, tx_dv, tx_byte
  );

  modport slave (
    input  req, req_byte, tx_active, tx_done,
    output grant, grant_id, busy, timeout, tx_dv, tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers, with optional inter-byte gap and a done-watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 0
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  ISSUE     = 2'd1;
  localparam logic [1:0]  WAIT_DONE = 2'd2;
  localparam logic [1:0]  GAP       = 2'd3;
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CLKS - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]  PTR_RST   = 3'(NUM_REQ - 1);

  logic [1:0]         state;
  logic [2:0]         ptr;
  logic               done_q;
  logic [15:0]        wd_cnt;
  logic [15:0]        gap_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         grant_id;
  logic               timeout;
  logic               tx_dv;
  logic [7:0]         tx_byte;

  logic [7:0]         req_pad;
  logic [7:0][7:0]    byte_pad;
  logic [3:0]         cand;
  logic [2:0]         win;
  logic               win_ok;
  logic [NUM_REQ-1:0] win_oh;
  logic               done_edge;
  logic               can_grant;

  // Search upward from ptr+1 with wrap; cand < 2*NUM_REQ so one subtract wraps.
  always_comb begin
    req_pad                   = '0;
    req_pad[NUM_REQ-1:0]      = bus.req;
    byte_pad                  = '0;
    byte_pad[NUM_REQ-1:0]     = bus.req_byte;
    cand   = '0;
    win    = '0;
    win_ok = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_ok && req_pad[cand[2:0]]) begin
        win_ok = 1'b1;
        win    = cand[2:0];
      end
    end
    win_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) win_oh[k] = (win == 3'(k));
  end

  // done_q resets high so a done level left over from before reset is not an edge.
  assign done_edge = bus.tx_done & ~done_q;
  assign can_grant = win_ok & ~bus.tx_active & ~bus.tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      done_q   <= 1'b1;
      wd_cnt   <= '0;
      gap_cnt  <= '0;
      grant    <= '0;
      grant_id <= '0;
      timeout  <= 1'b0;
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
    end else begin
      done_q  <= bus.tx_done;
      grant   <= '0;
      tx_dv   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            tx_dv    <= 1'b1;
            tx_byte  <= byte_pad[win];
            grant    <= win_oh;
            grant_id <= win;
            ptr      <= win;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done edge takes priority over a watchdog expiry in the same cycle.
          if (done_edge) begin
            gap_cnt <= '0;
            state   <= (GAP_CLKS != 0) ? GAP : IDLE;
          end else if (TIMEOUT_CLKS != 0) begin
            if (wd_cnt == TO_LAST) begin
              timeout <= 1'b1;
              state   <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + 16'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant;
  assign bus.grant_id = grant_id;
  assign bus.busy     = (state != IDLE);
  assign bus.timeout  = timeout;
  assign bus.tx_dv    = tx_dv;
  assign bus.tx_byte  = tx_byte;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers, e.g. the CPU output port, a debug dumper and a status reporter.
- Arbitrates round-robin and hands the winner's byte to the transmitter with a one-cycle data-valid pulse.
- Waits for the transmitter's completion, then inserts an optional inter-byte gap.
- A watchdog recovers the arbiter if the transmitter never reports completion.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CLKS, 0, idle clocks inserted after each completed byte before the next grant (0..65535).
- TIMEOUT_CLKS, 0, maximum clocks to wait for transmitter done after issue; 0 disables the watchdog (16-bit).

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester request; held high with its byte stable until granted.
- i_Req_Byte  in  8*NUM_REQ  requester k byte on bits [8k+7:8k].
- o_Grant  out  NUM_REQ  one-hot, one-cycle pulse: the byte of that requester was captured.
- o_Grant_Id  out  3  index of the most recent grant; holds between grants.
- o_Busy  out  1  high in any state except IDLE.
- o_Timeout  out  1  one-cycle pulse when the watchdog fires.
- o_Tx_DV  out  1  data-valid pulse to the transmitter.
- o_Tx_Byte  out  8  byte to the transmitter; holds its value after the pulse.
- i_Tx_Active  in  1  transmitter active flag.
- i_Tx_Done  in  1  transmitter done; may stay high for more than one cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- The transmitter has no reset. A frame in flight during reset is not aborted. After reset the arbiter grants only once i_Tx_Active=0 and i_Tx_Done=0.
- Done detection: completion is the rising edge of i_Tx_Done, taken against a registered copy of i_Tx_Done. That register resets to 1, so a done level still high after reset is not counted as an edge.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE, grant condition: any i_Req bit set, i_Tx_Active=0 and i_Tx_Done=0.
  - Winner: first set request found searching upward from pointer+1, with wrap-around modulo NUM_REQ.
  - On the next edge: o_Tx_DV=1, o_Tx_Byte=winner byte, o_Grant=one-hot(winner), o_Grant_Id=winner, pointer=winner, state ISSUE.
  - Grant latency from request seen to grant pulse is 1 clock.
- ISSUE: lasts one cycle. o_Tx_DV and o_Grant return to 0, the watchdog counter is cleared, and the state moves to WAIT_DONE.
- WAIT_DONE:
  - When TIMEOUT_CLKS≠0 the watchdog counter increments each cycle.
  - On a done rising edge: go to GAP if GAP_CLKS>0, else to IDLE.
  - If the counter reaches TIMEOUT_CLKS-1 with no edge: pulse o_Timeout for 1 cycle and go to IDLE. The IDLE grant condition still prevents reissue while the transmitter is busy.
  - A done edge and a timeout in the same cycle: the done edge wins and no timeout pulse is produced.
- GAP: counts GAP_CLKS cycles, then goes to IDLE.
- Requests and bytes are sampled only in IDLE. Requests arriving or dropping in other states have no effect.
- A requester that drops i_Req before being granted is simply not served; there is no latching.
- A granted requester whose i_Req stays high is eligible again. Round-robin guarantees every active requester is served within NUM_REQ grants.
- o_Grant is never multi-hot. At most one o_Tx_DV pulse is issued per completed, or timed-out, frame.
- Zero-gap back-to-back operation: the next grant happens once the transmitter has dropped done. Throughput is bounded by the transmitter frame time plus about 3 clocks.

Test Plan:
- Single request: transmitter modelled with CLKS_PER_BIT=4; req[2]=1 with byte 0xA5 -> o_Grant=0100 and o_Tx_DV pulse 1 clock after the request; o_Tx_Byte=0xA5; o_Busy high until done edge; one frame transmitted.
- Round-robin fairness: all four requests held high with bytes 0x10..0x13 -> grants in order 0,1,2,3,0; o_Grant_Id sequence 0,1,2,3,0; no grant while i_Tx_Active=1.
- Gap timing: GAP_CLKS=5; two requesters -> exactly 5 clocks in GAP between the done edge and return to IDLE; second o_Tx_DV 1 clock later.
- Long done level: transmitter holds done high for 2 cycles -> counted once; no duplicate issue; next grant only after done falls.
- Watchdog: TIMEOUT_CLKS=20; done never asserted and i_Tx_Active=0 -> o_Timeout pulse 20 clocks after ISSUE, back to IDLE, next pending request granted.
- Reset mid-frame: assert i_Reset while WAIT_DONE with i_Tx_Active=1 -> all outputs 0 after the edge; no o_Tx_DV until i_Tx_Active=0 and done=0; then requester 0 is granted first.
